// File: rtl/stdout_line_arbiter_if.sv
// Producer/sink bundle for stdout_line_arbiter: per-port beat handshake plus
// the sink FIFO write port. The arbiter uses the slave modport.
interface stdout_line_arbiter_if #(
    parameter int unsigned N_PORTS = 4
);
    logic [N_PORTS-1:0]    req_valid_i;
    logic [32*N_PORTS-1:0] req_data_i;
    logic [N_PORTS-1:0]    req_ready_o;
    logic                  fifo_full_i;
    logic                  fifo_almost_full_i;
    logic                  fifo_rst_busy_i;
    logic                  fifo_wr_en_o;
    logic [31:0]           fifo_din_o;

    modport slave (
        input  req_valid_i, req_data_i, fifo_full_i, fifo_almost_full_i, fifo_rst_busy_i,
        output req_ready_o, fifo_wr_en_o, fifo_din_o
    );

    modport master (
        output req_valid_i, req_data_i, fifo_full_i, fifo_almost_full_i, fifo_rst_busy_i,
        input  req_ready_o, fifo_wr_en_o, fifo_din_o
    );
endinterface

// File: rtl/stdout_line_arbiter.sv
// Line-atomic round-robin arbiter sharing one stdout FIFO write port.
// Optional per-port line / timeout statistics under STDOUT_ARB_STATS_EN.
module stdout_line_arbiter #(
    parameter  int unsigned N_PORTS        = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W          = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    stdout_line_arbiter_if.slave bus,
    output logic [IDX_W-1:0]     owner_o,
    output logic                 locked_o,
`ifdef STDOUT_ARB_STATS_EN
    output logic [16*N_PORTS-1:0] stat_lines_o,
    output logic [15:0]           stat_timeouts_o,
`endif
    output logic                 timeout_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CW    = IDX_W + 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               wr_en_q;
    logic [31:0]        din_q;

    logic               sink_ok;
    logic               found;
    logic [IDX_W-1:0]   grant;
    logic [CW-1:0]      cand;
    logic [IDX_W-1:0]   sel;
    logic [31:0]        beat;
    logic [N_PORTS-1:0] rdy;
    logic               xfer;
    logic               is_nl;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_PORTS - 1)) return '0;
        return idx + 1'b1;
    endfunction

    // wr_en_q && almost_full: the pending registered write takes the last slot
    assign sink_ok = !bus.fifo_full_i && !bus.fifo_rst_busy_i &&
                     !(wr_en_q && bus.fifo_almost_full_i);

    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand = {1'b0, rr_q} + CW'(i);
            if (cand >= CW'(N_PORTS)) cand = cand - CW'(N_PORTS);
            if (!found && bus.req_valid_i[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                grant = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        rdy       = '0;
        sel       = (state_q == IDLE) ? grant : owner_q;

        if (state_q == IDLE) begin
            if (sink_ok && found) rdy[grant] = 1'b1;
        end else begin
            rdy[owner_q] = sink_ok;
        end
        rdy = rst_ni ? rdy : '0;

        beat = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (IDX_W'(p) == sel) beat = bus.req_data_i[32*p +: 32];
        end
        xfer  = |(rdy & bus.req_valid_i);
        is_nl = (beat[7:0] == 8'h0A);

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (is_nl) begin
                        rr_d = next_idx(grant);
                    end else begin
                        state_d = LOCKED;
                        owner_d = grant;
                        cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (is_nl) begin
                        state_d = IDLE;
                        rr_d    = next_idx(owner_q);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    rr_d      = next_idx(owner_q);
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            wr_en_q   <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            wr_en_q   <= xfer;
            if (xfer) din_q <= {8'h00, beat[23:0]};
        end
    end

    assign bus.req_ready_o  = rdy;
    assign bus.fifo_wr_en_o = wr_en_q;
    assign bus.fifo_din_o   = din_q;
    assign owner_o          = owner_q;
    assign locked_o         = (state_q == LOCKED);
    assign timeout_o        = timeout_q;

`ifdef STDOUT_ARB_STATS_EN
    logic [N_PORTS-1:0][15:0] lines_q;
    logic [15:0]              tos_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lines_q <= '0;
            tos_q   <= '0;
        end else begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (xfer && is_nl && sel == IDX_W'(p) && lines_q[p] != '1)
                    lines_q[p] <= lines_q[p] + 1'b1;
            end
            if (timeout_q && tos_q != '1) tos_q <= tos_q + 1'b1;
        end
    end

    assign stat_lines_o    = lines_q;
    assign stat_timeouts_o = tos_q;
`endif
endmodule

// File: tb/tb_stdout_line_arbiter.sv
// Scoreboard bench for stdout_line_arbiter: directed line traffic, expected
// FIFO words queued at issue time and checked by an independent monitor.
module tb_stdout_line_arbiter;
    localparam int N     = 4;
    localparam int TO    = 1024;
    localparam int IDX_W = 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    stdout_line_arbiter_if #(.N_PORTS(N)) bus ();

    logic [IDX_W-1:0] owner;
    logic             locked;
    logic             timeout;
`ifdef STDOUT_ARB_STATS_EN
    logic [16*N-1:0]  stat_lines;
    logic [15:0]      stat_tos;
`endif

    stdout_line_arbiter #(.N_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .bus       (bus.slave),
        .owner_o   (owner),
        .locked_o  (locked),
`ifdef STDOUT_ARB_STATS_EN
        .stat_lines_o    (stat_lines),
        .stat_timeouts_o (stat_tos),
`endif
        .timeout_o (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  src_q [N][$];
    logic [N-1:0] hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input int p, input string s);
        for (int i = 0; i < s.len(); i++) begin
            src_q[p].push_back(s[i]);
            exp_q.push_back({8'h00, 8'(p * 16), 8'(p), 8'(s[i])});
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Source driver: a beat stays presented until it is seen accepted.
    initial begin
        logic [N-1:0] xf;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        forever begin
            @(negedge clk);
            xf = bus.req_valid_i & bus.req_ready_o;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (xf[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0 && !hold[p]) begin
                    bus.req_valid_i[p] = 1'b1;
                    bus.req_data_i[32*p +: 32] = {8'hA5, 8'(p * 16), 8'(p), src_q[p][0]};
                end else begin
                    bus.req_valid_i[p] = 1'b0;
                end
            end
        end
    end

    // Monitor: write latency, write data order, ready exclusivity under lock.
    initial begin
        logic xfer_last;
        xfer_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                xfer_last = 1'b0;
            end else begin
                check("wr_latency", 64'(bus.fifo_wr_en_o), 64'(xfer_last));
                if (bus.fifo_wr_en_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(bus.fifo_din_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("wr_data", 64'(bus.fifo_din_o), 64'(exp_q.pop_front()));
                    end
                end
                if (locked)
                    check("ready_owner_only", 64'(bus.req_ready_o & ~(4'b0001 << owner)), 64'd0);
                xfer_last = |(bus.req_valid_i & bus.req_ready_o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.fifo_full_i        = 1'b0;
        bus.fifo_almost_full_i = 1'b0;
        bus.fifo_rst_busy_i    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_wr_en_o), 64'd0);
        check("rst_din", 64'(bus.fifo_din_o), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        sync();
        rst_ni = 1'b1;

        // "hi\n" on port 0
        sync();
        src_q[0].push_back(8'h68); src_q[0].push_back(8'h69); src_q[0].push_back(8'h0A);
        exp_q.push_back(32'h0000_0068);
        exp_q.push_back(32'h0000_0069);
        exp_q.push_back(32'h0000_000A);
        drain("t1_drain");
        check("t1_unlocked", 64'(locked), 64'd0);

        // ports 1 and 2 contend: port 1's whole line first
        sync();
        send(1, "ab\n");
        send(2, "ab\n");
        drain("t2_drain");
        // pointer now 3: port 3 beats port 0
        sync();
        send(3, "\n");
        send(0, "\n");
        drain("t2b_drain");

        // timeout with port 3 waiting
        sync();
        hold[3] = 1'b1;
        send(0, "x");
        send(3, "z\n");
        c = 0;
        while (!locked && c < 50) begin @(negedge clk); c++; end
        check("t3_locked", 64'(locked), 64'd1);
        check("t3_owner", 64'(owner), 64'd0);
        hold[3] = 1'b0;
        c = 0;
        while (c < 2000) begin
            @(negedge clk);
            c++;
            if (timeout) break;
        end
        check("t3_timeout_cycles", 64'(c), 64'd1024);
        check("t3_released", 64'(locked), 64'd0);
        check("t3_grant3", 64'(bus.req_ready_o), 64'b1000);
        @(negedge clk);
        check("t3_pulse_once", 64'(timeout), 64'd0);
        check("t3_owner3", 64'({locked, owner}), 64'b111);
        drain("t3_drain");

        // almost-full backpressure behind a pending write
        sync();
        bus.fifo_almost_full_i = 1'b1;
        send(1, "abc\n");
        repeat (20) begin
            @(negedge clk);
            if (bus.fifo_wr_en_o) check("t4_af_block", 64'(bus.req_ready_o), 64'd0);
        end
        drain("t4_af_drain");
        sync();
        bus.fifo_almost_full_i = 1'b0;

        // full for 5 cycles mid-line
        send(2, "pqrs\n");
        c = 0;
        while (!bus.fifo_wr_en_o && c < 50) begin @(negedge clk); c++; end
        sync();
        bus.fifo_full_i = 1'b1;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("t4_full_no_wr", 64'(bus.fifo_wr_en_o), 64'd0);
            check("t4_full_no_rdy", 64'(bus.req_ready_o), 64'd0);
        end
        sync();
        bus.fifo_full_i = 1'b0;
        drain("t4_full_drain");

        // reset while port 2 is mid-line
        sync();
        send(2, "abcdef\n");
        c = 0;
        while (!(locked && owner == 2'd2) && c < 50) begin @(negedge clk); c++; end
        check("t5_owner2", 64'({locked, owner}), 64'b110);
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t5_locked", 64'(locked), 64'd0);
        check("t5_owner", 64'(owner), 64'd0);
        check("t5_wr_en", 64'(bus.fifo_wr_en_o), 64'd0);
        check("t5_din", 64'(bus.fifo_din_o), 64'd0);
        check("t5_timeout", 64'(timeout), 64'd0);
        check("t5_ready", 64'(bus.req_ready_o), 64'd0);
        exp_q.delete();
        for (int p = 0; p < N; p++) src_q[p].delete();
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        sync();
        send(0, "n\n");
        send(2, "m\n");
        drain("t5_drain");

        // two lines then a timeout on port 1
        sync();
        send(1, "a\n");
        send(1, "b\n");
        send(1, "c");
        drain("t6_drain");
        c = 0;
        while (!timeout && c < 1100) begin @(negedge clk); c++; end
        check("t6_timeout", 64'(timeout), 64'd1);
        @(negedge clk);
`ifdef STDOUT_ARB_STATS_EN
        check("t6_lines_p0", 64'(stat_lines[15:0]), 64'd1);
        check("t6_lines_p1", 64'(stat_lines[31:16]), 64'd2);
        check("t6_lines_p2", 64'(stat_lines[47:32]), 64'd1);
        check("t6_lines_p3", 64'(stat_lines[63:48]), 64'd0);
        check("t6_timeouts", 64'(stat_tos), 64'd1);
`endif
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
